// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared defaults and index helpers for the round-robin FIFO pop scheduler.
package fifo_rr_scheduler_pkg;

  localparam int unsigned DEF_NUM_FIFOS = 4;
  localparam int unsigned DEF_BURST     = 2;

  // Next index in a ring of n slots; works for any n, not only powers of two.
  function automatic int unsigned inc_mod(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_scheduler_pick.sv
// Rotating first-set scan: finds the first asserted request at or after start, wrapping.
module rr_priority_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    int unsigned pos;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(start) + k;
      if (pos >= N) pos = pos - N;
      if (!any && req[W'(pos)]) begin
        any               = 1'b1;
        onehot[W'(pos)]   = 1'b1;
        idx               = W'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin pop scheduler with burst ownership: zero-latency one-hot grant to a bank of FIFOs.
module fifo_rr_scheduler
  import fifo_rr_scheduler_pkg::*;
#(
  parameter  int unsigned NUM_FIFOS = DEF_NUM_FIFOS,
  parameter  int unsigned BURST     = DEF_BURST,
  localparam int unsigned TAGWIDTH  = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic                 out_rdy,
  output logic [NUM_FIFOS-1:0] gnt,
  output logic [TAGWIDTH-1:0]  gnt_sel,
  output logic                 gnt_vld,
  output logic [TAGWIDTH-1:0]  owner,
  output logic                 locked
);

  localparam int unsigned CW = $clog2(BURST + 1);

  logic [TAGWIDTH-1:0]  ptr_q, ptr_d;
  logic [TAGWIDTH-1:0]  owner_q, owner_d;
  logic                 locked_q, locked_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;

  logic [NUM_FIFOS-1:0] req;
  logic [NUM_FIFOS-1:0] pick_onehot;
  logic [TAGWIDTH-1:0]  pick_idx;
  logic                 pick_any;

  logic                 owner_ready, owner_gone, win_any, pop;
  logic [TAGWIDTH-1:0]  win_idx;
  logic [NUM_FIFOS-1:0] win_onehot;

  function automatic logic [TAGWIDTH-1:0] next_idx(input logic [TAGWIDTH-1:0] i);
    return TAGWIDTH'(inc_mod(32'(i), NUM_FIFOS));
  endfunction

  assign req = ~empty;

  rr_priority_pick #(
    .N(NUM_FIFOS),
    .W(TAGWIDTH)
  ) u_pick (
    .req   (req),
    .start (ptr_q),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The owner keeps the grant while it has data; otherwise fall back to the scan.
  always_comb begin
    owner_ready = locked_q & ~empty[owner_q];
    owner_gone  = locked_q &  empty[owner_q];
    win_idx     = owner_ready ? owner_q : pick_idx;
    win_onehot  = owner_ready ? (NUM_FIFOS'(1) << owner_q) : pick_onehot;
    win_any     = owner_ready | pick_any;
    pop         = win_any & out_rdy & rst;
  end

  always_comb begin
    gnt     = '0;
    gnt_sel = '0;
    if (pop) begin
      gnt     = win_onehot;
      gnt_sel = win_idx;
    end
  end

  assign gnt_vld = |gnt;
  assign owner   = owner_q;
  assign locked  = locked_q;

  always_comb begin
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + CW'(1);

    if (owner_gone) begin
      locked_d = 1'b0;
      cnt_d    = '0;
      ptr_d    = next_idx(owner_q);
    end

    if (pop) begin
      if (owner_ready) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(BURST)) begin
          locked_d = 1'b0;
          cnt_d    = '0;
          ptr_d    = next_idx(owner_q);
        end
      end else begin
        owner_d = win_idx;
        cnt_d   = CW'(1);
        if (BURST == 1) begin
          locked_d = 1'b0;
          ptr_d    = next_idx(win_idx);
        end else begin
          // A new burst starting in a release cycle overrides the release pointer move.
          locked_d = 1'b1;
          ptr_d    = ptr_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
    end
  end

  a_gnt_legal: assert property (@(posedge clk) disable iff (!rst)
    (((gnt & empty) == '0) && $onehot0(gnt)));

  a_ptr_range: assert property (@(posedge clk) disable iff (!rst)
    (32'(ptr_q) < NUM_FIFOS));

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: directed scenarios plus random traffic against a queue-free rule model.
module tb_fifo_rr_scheduler;

  localparam int NF = 4;
  localparam int B  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] empty = 4'hF;
  logic       out_rdy = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_sel;
  logic       gnt_vld;
  logic [1:0] owner;
  logic       locked;

  int total = 0;
  int bad   = 0;

  int m_ptr, m_owner, m_cnt;
  bit m_locked;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(
    .NUM_FIFOS(NF),
    .BURST(B)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .empty  (empty),
    .out_rdy(out_rdy),
    .gnt    (gnt),
    .gnt_sel(gnt_sel),
    .gnt_vld(gnt_vld),
    .owner  (owner),
    .locked (locked)
  );

  function automatic bit is_empty(input logic [3:0] e, input int i);
    return ((e >> i) & 4'd1) != 4'd0;
  endfunction

  function automatic int model_winner(input logic [3:0] e);
    if (m_locked && !is_empty(e, m_owner)) return m_owner;
    for (int k = 0; k < NF; k++)
      if (!is_empty(e, (m_ptr + k) % NF)) return (m_ptr + k) % NF;
    return -1;
  endfunction

  function automatic logic [3:0] model_gnt(input logic [3:0] e, input logic r);
    int w;
    w = model_winner(e);
    if (!r || w < 0) return 4'd0;
    return 4'd1 << w;
  endfunction

  function automatic logic [1:0] model_sel(input logic [3:0] e, input logic r);
    int w;
    w = model_winner(e);
    if (!r || w < 0) return 2'd0;
    return 2'(w);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
  endtask

  task automatic model_advance(input logic [3:0] e, input logic r);
    int w, n_ptr, n_owner, n_cnt;
    bit n_locked, pop;
    w = model_winner(e);
    pop = r && (w >= 0);
    n_ptr = m_ptr; n_owner = m_owner; n_cnt = m_cnt; n_locked = m_locked;
    if (m_locked && is_empty(e, m_owner)) begin
      n_locked = 1'b0; n_cnt = 0; n_ptr = (m_owner + 1) % NF;
    end
    if (pop) begin
      if (m_locked && w == m_owner) begin
        n_cnt = m_cnt + 1;
        if (n_cnt == B) begin
          n_locked = 1'b0; n_cnt = 0; n_ptr = (m_owner + 1) % NF;
        end
      end else begin
        n_owner = w; n_cnt = 1;
        if (B == 1) begin
          n_locked = 1'b0; n_ptr = (w + 1) % NF;
        end else begin
          n_locked = 1'b1; n_ptr = m_ptr;
        end
      end
    end
    m_ptr = n_ptr; m_owner = n_owner; m_cnt = n_cnt; m_locked = n_locked;
  endtask

  task automatic drive(input logic [3:0] e, input logic r);
    empty = e;
    out_rdy = r;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    model_advance(empty, out_rdy);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; empty = 4'b0000; out_rdy = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    total++; if (gnt_sel !== 2'd0) begin bad++; $display("FAIL rst_sel: got %0d want 0", gnt_sel); end
    total++; if (gnt_vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got %b want 0", gnt_vld); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL rst_owner: got %0d want 0", owner); end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL first_gnt: got %b want 0001", gnt); end
    total++; if (gnt_sel !== 2'd0) begin bad++; $display("FAIL first_sel: got %0d want 0", gnt_sel); end
    step();
    total++; if (locked !== 1'b1 || owner !== 2'd0) begin
      bad++; $display("FAIL first_lock: got locked=%b owner=%0d want locked=1 owner=0", locked, owner);
    end
  endtask

  task automatic test_all_active();
    int seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(4'b0000, 1'b1);
      total++; if (gnt_sel !== 2'(seq[i])) begin bad++; $display("FAIL all_sel[%0d]: got %0d want %0d", i, gnt_sel, seq[i]); end
      total++; if (gnt !== model_gnt(empty, out_rdy)) begin bad++; $display("FAIL all_gnt[%0d]: got %b want %b", i, gnt, model_gnt(empty, out_rdy)); end
      step();
    end
  endtask

  task automatic test_sparse();
    int seq[5] = '{1, 1, 3, 3, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0101, 1'b1);
      total++; if (gnt_sel !== 2'(seq[i])) begin bad++; $display("FAIL sparse_sel[%0d]: got %0d want %0d", i, gnt_sel, seq[i]); end
      total++; if ((gnt & 4'b0101) !== 4'b0000 || gnt_vld !== 1'b1) begin
        bad++; $display("FAIL sparse_gnt[%0d]: got gnt=%b vld=%b want no bit 0/2, vld=1", i, gnt, gnt_vld);
      end
      step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(4'b0000, 1'b1); step(); end
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b0);
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL stall_gnt[%0d]: got %b want 0000", i, gnt); end
      step();
      total++; if (locked !== 1'b1 || owner !== 2'd2) begin
        bad++; $display("FAIL stall_hold[%0d]: got locked=%b owner=%0d want locked=1 owner=2", i, locked, owner);
      end
    end
    drive(4'b0000, 1'b1);
    total++; if (gnt_sel !== 2'd2) begin bad++; $display("FAIL stall_resume: got %0d want 2", gnt_sel); end
    step();
    drive(4'b0000, 1'b1);
    total++; if (gnt_sel !== 2'd3) begin bad++; $display("FAIL stall_rotate: got %0d want 3", gnt_sel); end
    step();
  endtask

  task automatic test_release();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(4'b0000, 1'b1); step(); end
    drive(4'b0010, 1'b1);
    total++; if (gnt_sel !== 2'd2 || gnt !== 4'b0100) begin
      bad++; $display("FAIL release_grant: got sel=%0d gnt=%b want sel=2 gnt=0100", gnt_sel, gnt);
    end
    step();
    total++; if (locked !== 1'b1 || owner !== 2'd2) begin
      bad++; $display("FAIL release_owner: got locked=%b owner=%0d want locked=1 owner=2", locked, owner);
    end
  endtask

  task automatic test_midburst_reset();
    do_reset();
    for (int i = 0; i < 7; i++) begin drive(4'b0000, 1'b1); step(); end
    drive(4'b0000, 1'b1);
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL mid_owner3: got %b want 1000", gnt); end
    rst = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      bad++; $display("FAIL mid_rst_gnt: got gnt=%b vld=%b want 0000/0", gnt, gnt_vld);
    end
    total++; if (locked !== 1'b0 || owner !== 2'd0) begin
      bad++; $display("FAIL mid_rst_state: got locked=%b owner=%0d want 0/0", locked, owner);
    end
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (gnt_sel !== 2'd0 || gnt !== 4'b0001) begin
      bad++; $display("FAIL mid_after: got sel=%0d gnt=%b want 0/0001", gnt_sel, gnt);
    end
    step();
  endtask

  task automatic test_random();
    logic [3:0] e;
    logic r;
    logic [3:0] eg;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      e = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 15) == 0) e = 4'hF;
      if ($urandom_range(0, 9) == 0) e = 4'h0;
      r = ($urandom_range(0, 3) != 0);
      drive(e, r);
      eg = model_gnt(e, r);
      total++; if (gnt !== eg) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b (empty=%b rdy=%b)", i, gnt, eg, e, r); end
      total++; if (gnt_sel !== model_sel(e, r)) begin bad++; $display("FAIL rnd_sel[%0d]: got %0d want %0d", i, gnt_sel, model_sel(e, r)); end
      total++; if (gnt_vld !== (eg != 4'd0)) begin bad++; $display("FAIL rnd_vld[%0d]: got %b want %b", i, gnt_vld, (eg != 4'd0)); end
      step();
      total++; if (locked !== m_locked) begin bad++; $display("FAIL rnd_locked[%0d]: got %b want %b", i, locked, m_locked); end
      if (m_locked) begin
        total++; if (owner !== 2'(m_owner)) begin bad++; $display("FAIL rnd_owner[%0d]: got %0d want %0d", i, owner, m_owner); end
      end
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b0;
        #1;
        total++; if (gnt !== 4'b0000 || locked !== 1'b0) begin
          bad++; $display("FAIL rnd_rst[%0d]: got gnt=%b locked=%b want 0000/0", i, gnt, locked);
        end
        rst = 1'b1;
        model_reset();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_all_active();
    test_sparse();
    test_stall();
    test_release();
    test_midburst_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_FIFOS, default 4: number of requesting FIFOs; legal range 2..16.
REQ-002 SHALL have parameter BURST, default 2: maximum consecutive pops granted to one FIFO before rotation; legal range 1..15.
REQ-003 SHALL have derived parameter TAGWIDTH = $clog2(NUM_FIFOS): width of encoded FIFO index.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 empty  input  NUM_FIFOS  per-FIFO empty flag; bit i = 1 means FIFO i has no data.
REQ-007 out_rdy  input  1  downstream accepts one word this cycle.
REQ-008 gnt  output  NUM_FIFOS  one-hot pop/select; drives FIFO pop and onehot_mux select directly.
REQ-009 gnt_sel  output  TAGWIDTH  encoded index of the granted FIFO; 0 when gnt_vld = 0.
REQ-010 gnt_vld  output  1  a pop occurs this cycle (OR of gnt).
REQ-011 owner  output  TAGWIDTH  current burst owner; valid when locked = 1.
REQ-012 locked  output  1  a burst is in progress.

Function
REQ-013 SHALL hold state registers: ptr (TAGWIDTH, next priority start), owner (TAGWIDTH), locked (1), cnt ($clog2(BURST+1) bits, pops granted in current burst).
REQ-014 Winner selection SHALL be combinational: if locked and !empty[owner], winner = owner; otherwise winner = first i with !empty[i], scanning ptr, ptr+1, ... modulo NUM_FIFOS.
REQ-015 gnt SHALL be one-hot of winner when a winner exists, out_rdy = 1 and rst = 1; otherwise gnt = 0 (zero-latency grant, same cycle).
REQ-016 gnt[i] SHALL never be 1 while empty[i] = 1; gnt SHALL always be one-hot or zero.
REQ-017 On a pop where the winner is not the locked owner: owner <= winner, cnt <= 1; if BURST = 1, locked <= 0 and ptr <= winner+1 mod NUM_FIFOS; else locked <= 1.
REQ-018 On a pop by the locked owner: cnt <= cnt+1; when cnt+1 = BURST, locked <= 0, cnt <= 0, ptr <= owner+1 mod NUM_FIFOS.
REQ-019 While locked and empty[owner] = 1: locked <= 0, cnt <= 0, ptr <= owner+1 mod NUM_FIFOS on the next edge; a new winner MAY be granted in that same cycle per REQ-014, and then REQ-017 takes precedence over the ptr update.
REQ-020 out_rdy = 0 SHALL freeze ptr, owner, locked and cnt (except the REQ-019 release) and force gnt = 0.
REQ-021 All FIFOs empty SHALL give gnt = 0 with state unchanged.
REQ-022 ptr wrap-around SHALL be modulo NUM_FIFOS, correct for non-power-of-two NUM_FIFOS; ptr SHALL never hold a value >= NUM_FIFOS.

Reset
REQ-023 rst = 0 SHALL immediately (asynchronously) set ptr = 0, owner = 0, locked = 0, cnt = 0, and force gnt = 0, gnt_vld = 0, gnt_sel = 0.
REQ-024 The first edge after rst deasserts SHALL apply normal selection from ptr = 0.
REQ-025 Reset asserted mid-burst SHALL abandon the burst with no further pop.

Structure
REQ-026 A shared package SHALL hold the NUM_FIFOS/BURST defaults and the index-increment-modulo function, shared with the FIFO top.
REQ-027 One combinational sub-module rr_priority_pick (inputs: request vector, start index; outputs: one-hot, encoded index, any) SHALL implement the rotating scan.

Verification
REQ-028 Use NUM_FIFOS=4, BURST=2 unless stated; embed formal asserts for REQ-016 and REQ-022.
REQ-029 Reset: rst=0, empty=4'b0000, out_rdy=1 -> gnt=0; release rst -> first cycle gnt=4'b0001, gnt_sel=0.
REQ-030 All non-empty, out_rdy=1 held -> gnt_sel sequence 0,0,1,1,2,2,3,3,0.
REQ-031 empty=4'b0101 held -> gnt_sel sequence 1,1,3,3,1; gnt[0] and gnt[2] never 1.
REQ-032 Owner 2 after one pop, out_rdy=0 for 3 cycles -> gnt=0, locked=1, cnt=1 held; out_rdy=1 -> gnt_sel 2 once, then 3.
REQ-033 Owner 1 after one pop, empty[1] rises -> same cycle gnt_sel=2, locked=1, owner=2 next edge.
REQ-034 rst=0 pulse mid-burst of owner 3 -> gnt=0 immediately; after release gnt_sel=0.
